sign_convert_bcd: RTL and testbench

- Parametrised successor to the lab-2 8-bit sign changer.
- Captures a W-bit two's-complement operand on a load-button edge and applies a selectable operation: pass, negate or absolute value.
- Flags overflow and produces a sign bit plus a BCD magnitude of the result, using a sequential double-dabble converter.
- Sits between the switch/button inputs and the multi-digit 7-segment display controller.

---
 rtl/sign_convert_bcd.sv | 119 +++++++++++
 tb/tb_sign_convert_bcd.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/sign_convert_bcd.sv
// sign_convert_bcd: captures a two's-complement operand on a load edge,
// applies pass / negate / absolute value, flags overflow, and converts the
// result magnitude to BCD with a sequential double-dabble shifter.
module sign_convert_bcd #(
  parameter int W      = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clkin,
  input  logic                  rst_n,
  input  logic [W-1:0]          din,
  input  logic                  load,
  input  logic [1:0]            mode,
  output logic [W-1:0]          result,
  output logic                  ovfl,
  output logic                  neg,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  busy,
  output logic                  done
);

  localparam int CW = $clog2(W + 1);
  localparam int BW = 4 * DIGITS;

  typedef enum logic {IDLE, CONV} state_t;

  state_t          state;
  logic            load_q;
  logic [CW-1:0]   count;
  logic [W-1:0]    mag;
  logic [BW-1:0]   scratch;

  logic            start;
  logic [W-1:0]    negated;
  logic [W-1:0]    op_result;
  logic [W-1:0]    op_mag;
  logic            op_ovfl;
  logic            is_min;
  logic [BW-1:0]   adjusted;
  logic [BW-1:0]   next_scratch;

  // A press is only the low-to-high transition of the button level.
  assign start = load & ~load_q;

  // Operation result, overflow and unsigned magnitude of the result.
  always_comb begin
    negated   = ~din + 1'b1;
    is_min    = (din == {1'b1, {(W-1){1'b0}}});
    op_result = din;
    op_ovfl   = 1'b0;
    case (mode)
      2'b01: begin
        op_result = negated;
        op_ovfl   = is_min;
      end
      2'b10: begin
        if (din[W-1]) op_result = negated;
        op_ovfl = is_min;
      end
      default: ;
    endcase
    op_mag = op_result[W-1] ? (~op_result + 1'b1) : op_result;
  end

  // One double-dabble step: add 3 to digits >= 5, then shift in the next bit.
  always_comb begin
    adjusted = scratch;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) adjusted[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
    next_scratch = {adjusted[BW-2:0], mag[W-1]};
  end

  // Control FSM with capture, conversion datapath and registered outputs.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      load_q  <= 1'b1;
      count   <= '0;
      mag     <= '0;
      scratch <= '0;
      result  <= '0;
      ovfl    <= 1'b0;
      neg     <= 1'b0;
      bcd     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      load_q <= load;
      done   <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            result  <= op_result;
            ovfl    <= op_ovfl;
            neg     <= op_result[W-1];
            mag     <= op_mag;
            scratch <= '0;
            count   <= '0;
            busy    <= 1'b1;
            state   <= CONV;
          end
        end
        CONV: begin
          scratch <= next_scratch;
          mag     <= {mag[W-2:0], 1'b0};
          count   <= count + 1'b1;
          if (count == CW'(W - 1)) begin
            bcd   <= next_scratch;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sign_convert_bcd.sv
// tb_sign_convert_bcd: directed vectors with hand-computed expectations for
// an 8-bit/3-digit and a 16-bit/5-digit instance sharing clock and reset.
module tb_sign_convert_bcd;

  logic        clkin = 1'b0;
  logic        rst_n;

  logic [7:0]  din8;
  logic        load8;
  logic [1:0]  mode8;
  logic [7:0]  result8;
  logic        ovfl8, neg8, busy8, done8;
  logic [11:0] bcd8;

  logic [15:0] din16;
  logic        load16;
  logic [1:0]  mode16;
  logic [15:0] result16;
  logic        ovfl16, neg16, busy16, done16;
  logic [19:0] bcd16;

  int vectors = 0;
  int miscompares = 0;
  int done8_pulses = 0;
  int sel = 8;

  logic [31:0] cur_result, cur_bcd;
  logic        cur_ovfl, cur_neg, cur_busy, cur_done;

  sign_convert_bcd #(.W(8), .DIGITS(3)) dut8 (
    .clkin(clkin), .rst_n(rst_n), .din(din8), .load(load8), .mode(mode8),
    .result(result8), .ovfl(ovfl8), .neg(neg8), .bcd(bcd8), .busy(busy8), .done(done8)
  );

  sign_convert_bcd #(.W(16), .DIGITS(5)) dut16 (
    .clkin(clkin), .rst_n(rst_n), .din(din16), .load(load16), .mode(mode16),
    .result(result16), .ovfl(ovfl16), .neg(neg16), .bcd(bcd16), .busy(busy16), .done(done16)
  );

  // Free-running clock.
  always #5 clkin = ~clkin;

  // Count done pulses of the 8-bit instance, sampled away from the active edge.
  always @(negedge clkin) if (done8) done8_pulses++;

  // Route the selected instance's outputs to common observation signals.
  always_comb begin
    if (sel == 16) begin
      cur_result = 32'(result16);
      cur_bcd    = 32'(bcd16);
      cur_ovfl   = ovfl16;
      cur_neg    = neg16;
      cur_busy   = busy16;
      cur_done   = done16;
    end else begin
      cur_result = 32'(result8);
      cur_bcd    = 32'(bcd8);
      cur_ovfl   = ovfl8;
      cur_neg    = neg8;
      cur_busy   = busy8;
      cur_done   = done8;
    end
  end

  // Count one comparison and report it if it differs.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Press load on one instance, check the captured outputs, then check the
  // conversion latency, the held bcd mid-conversion, and the final bcd.
  task automatic applyStimulus(input int w, input logic [15:0] d, input logic [1:0] m,
                               input logic [15:0] exp_res, input logic exp_ovfl,
                               input logic exp_neg, input logic [19:0] exp_bcd);
    int edges;
    logic [31:0] prev_bcd;
    sel = w;
    @(negedge clkin);
    prev_bcd = cur_bcd;
    if (w == 16) begin
      din16 = d; mode16 = m; load16 = 1'b1;
    end else begin
      din8 = d[7:0]; mode8 = m; load8 = 1'b1;
    end
    @(posedge clkin); #1;
    checkOutput("result", cur_result, 32'(exp_res));
    checkOutput("ovfl", 32'(cur_ovfl), 32'(exp_ovfl));
    checkOutput("neg", 32'(cur_neg), 32'(exp_neg));
    checkOutput("busy_start", 32'(cur_busy), 32'd1);
    @(negedge clkin);
    load8 = 1'b0; load16 = 1'b0;
    din8 = 8'h00; din16 = 16'h0000; mode8 = 2'b00; mode16 = 2'b00;
    edges = 0;
    while (!cur_done && edges < 64) begin
      @(posedge clkin); #1;
      edges++;
      if (edges == 4) checkOutput("bcd_hold", cur_bcd, prev_bcd);
    end
    checkOutput("latency", 32'(edges), 32'(w));
    checkOutput("bcd", cur_bcd, 32'(exp_bcd));
    checkOutput("busy_end", 32'(cur_busy), 32'd0);
    @(posedge clkin); #1;
    checkOutput("done_pulse", 32'(cur_done), 32'd0);
  endtask

  initial begin
    int busy_seen;
    int pulses_before;
    rst_n = 1'b0;
    load8 = 1'b1; load16 = 1'b1;
    din8 = 8'h00; din16 = 16'h0000; mode8 = 2'b00; mode16 = 2'b00;
    repeat (3) @(posedge clkin);
    #1;
    checkOutput("rst_result", 32'(result8), 32'd0);
    checkOutput("rst_bcd", 32'(bcd8), 32'd0);
    checkOutput("rst_busy", 32'(busy8), 32'd0);
    checkOutput("rst_done", 32'(done8), 32'd0);
    checkOutput("rst_ovfl_neg", {30'd0, ovfl8, neg8}, 32'd0);

    // Load held high through reset release must not start a conversion.
    @(negedge clkin);
    rst_n = 1'b1;
    busy_seen = 0;
    repeat (12) begin
      @(posedge clkin); #1;
      if (busy8 || busy16) busy_seen = 1;
    end
    checkOutput("held_load_no_conv", 32'(busy_seen), 32'd0);
    @(negedge clkin);
    load8 = 1'b0; load16 = 1'b0;
    @(posedge clkin);

    applyStimulus(8, 16'h001B, 2'b01, 16'h00E5, 1'b0, 1'b1, 20'h027);
    applyStimulus(8, 16'h00E7, 2'b10, 16'h0019, 1'b0, 1'b0, 20'h025);
    applyStimulus(8, 16'h00E7, 2'b00, 16'h00E7, 1'b0, 1'b1, 20'h025);
    applyStimulus(8, 16'h0080, 2'b01, 16'h0080, 1'b1, 1'b1, 20'h128);
    applyStimulus(8, 16'h0080, 2'b10, 16'h0080, 1'b1, 1'b1, 20'h128);
    applyStimulus(8, 16'h0080, 2'b00, 16'h0080, 1'b0, 1'b1, 20'h128);
    applyStimulus(8, 16'h0063, 2'b10, 16'h0063, 1'b0, 1'b0, 20'h099);
    applyStimulus(8, 16'h0005, 2'b11, 16'h0005, 1'b0, 1'b0, 20'h005);
    applyStimulus(8, 16'h0000, 2'b01, 16'h0000, 1'b0, 1'b0, 20'h000);

    // A second load edge three cycles into the conversion is ignored.
    sel = 8;
    pulses_before = done8_pulses;
    @(negedge clkin);
    din8 = 8'h1B; mode8 = 2'b01; load8 = 1'b1;
    @(posedge clkin);
    @(negedge clkin);
    load8 = 1'b0; din8 = 8'h05; mode8 = 2'b00;
    repeat (3) @(posedge clkin);
    @(negedge clkin);
    load8 = 1'b1;
    @(negedge clkin);
    load8 = 1'b0;
    repeat (20) @(posedge clkin);
    #1;
    checkOutput("busy_ignore_single_done", 32'(done8_pulses - pulses_before), 32'd1);
    checkOutput("busy_ignore_result", 32'(result8), 32'hE5);
    checkOutput("busy_ignore_bcd", 32'(bcd8), 32'h027);

    // Reset asserted on the fourth conversion edge aborts with no done pulse.
    pulses_before = done8_pulses;
    @(negedge clkin);
    din8 = 8'hE7; mode8 = 2'b10; load8 = 1'b1;
    @(posedge clkin);
    @(negedge clkin);
    load8 = 1'b0;
    repeat (4) @(posedge clkin);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_result", 32'(result8), 32'd0);
    checkOutput("abort_bcd", 32'(bcd8), 32'd0);
    checkOutput("abort_busy_done", {30'd0, busy8, done8}, 32'd0);
    checkOutput("abort_ovfl_neg", {30'd0, ovfl8, neg8}, 32'd0);
    @(negedge clkin);
    rst_n = 1'b1;
    repeat (12) @(posedge clkin);
    #1;
    checkOutput("abort_no_done", 32'(done8_pulses - pulses_before), 32'd0);
    applyStimulus(8, 16'h00E7, 2'b10, 16'h0019, 1'b0, 1'b0, 20'h025);

    applyStimulus(16, 16'h8000, 2'b01, 16'h8000, 1'b1, 1'b1, 20'h32768);
    applyStimulus(16, 16'h7FFF, 2'b01, 16'h8001, 1'b0, 1'b1, 20'h32767);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
